// File: rtl/goofy_alu_sequencer.sv
// goofy_alu_sequencer: request/response front end for the GoofyALU.
// One request is turned into an operand-load cycle (LOAD), then one op strobe
// cycle (EXEC). The ALU result and flags are then held as a response (DONE).
module goofy_alu_sequencer #(
   parameter bit HLT_BLOCK = 1'b1
) (
   input  logic       clk,
   input  logic       res,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_ov,
   output logic       rsp_eq,
   output logic       rsp_hlt,
   output logic       rsp_err,
   output logic       alu0w,
   output logic       alu1w,
   output logic [7:0] alu0d,
   output logic [7:0] alu1d,
   output logic       alu_add,
   output logic       alu_add_ov,
   output logic       alu_sub,
   output logic       alu_sub_ov,
   output logic       alu_and,
   output logic       alu_or,
   output logic       alu_not,
   output logic       alu_cmp,
   output logic       alu_hlt,
   output logic       alu_flag_res,
   input  logic [7:0] alu_out_i,
   input  logic       alu_flag_ov_i,
   input  logic       alu_flag_eq_i,
   input  logic       alu_flag_hlt_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] OP_HLT      = 4'd8;
   localparam logic [3:0] OP_FLAG_RES = 4'd9;

   logic [1:0] state;
   logic [3:0] op_q;    // latched opcode; operands live in alu0d/alu1d
   logic [9:0] strb_q;  // one-hot op strobes, bit i = opcode i

   // Opcode to one-hot strobe vector; only called with legal opcodes 0-9.
   function automatic logic [9:0] op_onehot(input logic [3:0] op);
      logic [9:0] v;
      v = '0;
      for (int i = 0; i < 10; i++)
         if (op == 4'(i)) v[i] = 1'b1;
      return v;
   endfunction

   logic op_illegal, op_blocked, op_reject, op_no_load;

   // Accept-time classification of the incoming request.
   always_comb begin
      op_illegal = (req_op > OP_FLAG_RES);
      op_blocked = HLT_BLOCK && alu_flag_hlt_i && (req_op != OP_FLAG_RES);
      op_reject  = op_illegal || op_blocked;
      op_no_load = (req_op == OP_HLT) || (req_op == OP_FLAG_RES);
   end

   // Sequencer FSM; every ALU-side output is a flop so strobes are glitch free.
   always_ff @(posedge clk) begin
      if (res) begin
         state    <= S_IDLE;
         op_q     <= '0;
         strb_q   <= '0;
         alu0w    <= 1'b0;
         alu1w    <= 1'b0;
         alu0d    <= '0;
         alu1d    <= '0;
         rsp_data <= '0;
         rsp_ov   <= 1'b0;
         rsp_eq   <= 1'b0;
         rsp_hlt  <= 1'b0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q <= req_op;
                  if (op_reject) begin
                     // ALU left untouched; report its current flags
                     state    <= S_DONE;
                     rsp_err  <= 1'b1;
                     rsp_data <= '0;
                     rsp_ov   <= alu_flag_ov_i;
                     rsp_eq   <= alu_flag_eq_i;
                     rsp_hlt  <= alu_flag_hlt_i;
                  end else if (op_no_load) begin
                     // hlt/flag_res do not touch the operand registers
                     state  <= S_EXEC;
                     strb_q <= op_onehot(req_op);
                  end else begin
                     state <= S_LOAD;
                     alu0w <= 1'b1;
                     alu1w <= 1'b1;
                     alu0d <= req_a;
                     alu1d <= req_b;
                  end
               end
            end
            S_LOAD: begin
               state  <= S_EXEC;
               alu0w  <= 1'b0;
               alu1w  <= 1'b0;
               alu0d  <= '0;
               alu1d  <= '0;
               strb_q <= op_onehot(op_q);
            end
            S_EXEC: begin
               // flags settled on the mid-cycle negedge; sample at closing edge
               state    <= S_DONE;
               strb_q   <= '0;
               rsp_data <= alu_out_i;
               rsp_ov   <= alu_flag_ov_i;
               rsp_eq   <= alu_flag_eq_i;
               rsp_hlt  <= alu_flag_hlt_i;
               rsp_err  <= 1'b0;
            end
            default: begin
               if (rsp_ready) state <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs: ready only in IDLE and never while reset is applied.
   assign req_ready = (state == S_IDLE) && !res;
   assign rsp_valid = (state == S_DONE);

   assign alu_add      = strb_q[0];
   assign alu_add_ov   = strb_q[1];
   assign alu_sub      = strb_q[2];
   assign alu_sub_ov   = strb_q[3];
   assign alu_and      = strb_q[4];
   assign alu_or       = strb_q[5];
   assign alu_not      = strb_q[6];
   assign alu_cmp      = strb_q[7];
   assign alu_hlt      = strb_q[8];
   assign alu_flag_res = strb_q[9];

endmodule

// File: doc/goofy_alu_sequencer.md
# goofy_alu_sequencer

Request-driven front end for the GoofyALU. It accepts one operation per valid/ready request (opcode plus two 8-bit operands) and drives the ALU's operand-write and one-hot operation strobes in the required order. It then captures `alu_out` and the three flags and returns them as a held response. It sits directly upstream of the ALU, between the instruction decode/bus logic and the ALU's control pins.

## Interface
Parameters:
- `HLT_BLOCK`, 1, when 1, reject every request except `flag_res` while the ALU halt flag is set.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `res`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  4  0 add, 1 add_ov, 2 sub, 3 sub_ov, 4 and, 5 or, 6 not, 7 cmp, 8 hlt, 9 flag_res, 10-15 illegal.
- `req_a`, `req_b`  in  8  operands destined for ALU registers 0 and 1.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_data`  out  8  captured `alu_out`.
- `rsp_ov`, `rsp_eq`, `rsp_hlt`  out  1 each  captured ALU flags.
- `rsp_err`  out  1  request rejected; ALU untouched.
- `alu0w`, `alu1w`  out  1 each  ALU register write enables.
- `alu0d`, `alu1d`  out  8 each  ALU register write data.
- `alu_add`, `alu_add_ov`, `alu_sub`, `alu_sub_ov`, `alu_and`, `alu_or`, `alu_not`, `alu_cmp`, `alu_hlt`, `alu_flag_res`  out  1 each  one-hot operation strobes.
- `alu_out_i`  in  8  ALU combinational result.
- `alu_flag_ov_i`, `alu_flag_eq_i`, `alu_flag_hlt_i`  in  1 each  ALU flags.

## Operation
- States: IDLE, LOAD, EXEC, DONE.
- IDLE:
  - `req_ready`=1. On `req_valid`, latch op, a and b.
  - If the op is illegal, or `HLT_BLOCK`=1, `alu_flag_hlt_i`=1 and op≠9: go to DONE with `rsp_err`=1, `rsp_data`=0 and flags copied from the inputs.
  - Else if op is 8 or 9: go to EXEC, skipping LOAD, so the ALU registers are unchanged.
  - Else: go to LOAD.
- LOAD: `alu0w`=`alu1w`=1, `alu0d`=a, `alu1d`=b; the ALU registers update at the end of this cycle. Always go to EXEC. The `not` op also loads b (harmless).
- EXEC:
  - Exactly one strobe is high, selected by the latched op.
  - The ALU updates its flags on the mid-cycle negedge.
  - At the closing posedge, capture `alu_out_i` into `rsp_data` and the three flag inputs into `rsp_ov/eq/hlt`; set `rsp_err`=0. Go to DONE.
- DONE: `rsp_valid`=1 and all response outputs held stable. When `rsp_ready`=1 at a posedge, go to IDLE.
- All ALU-side outputs come from registers. Outside LOAD/EXEC they are 0, and at most one op strobe is ever high.
- Ops 7-9 return `rsp_data`=0, because the ALU drives 0 when no arithmetic strobe is set.
- No arithmetic is done here. The sequencer does not interpret the sticky ov flag; it reports the ALU's value.

## Timing
- Reset: state IDLE. `req_ready`=0 during the reset cycle and 1 after it. All strobes, write enables, `alu0d/alu1d`, `rsp_*` outputs and the latched op/operands are 0.
- Accept at posedge k:
  - Ops 0-7: LOAD in cycle k+1, EXEC in k+2, `rsp_valid` from k+3.
  - Ops 8-9: EXEC in k+1, `rsp_valid` from k+2.
  - Rejected requests: `rsp_valid` from k+1.
- `req_ready` is 0 in LOAD, EXEC and DONE. There is no same-cycle handoff: after the DONE handshake at posedge m, the next accept is at the earliest at posedge m+1. Peak throughput is one add per 4 cycles.
- `rsp_valid` does not depend combinationally on `rsp_ready`. The response stays stable for any amount of backpressure.
- `res` during LOAD, EXEC or DONE forces IDLE at that posedge. All strobes are 0 in the next cycle and any pending response is dropped. ALU register contents already written are not rolled back.
- `req_valid` together with `res` is ignored.

## Test plan
- Add with overflow: op 0, a=0xF0, b=0x20, `rsp_ready`=1 → `alu0w`/`alu1w` at k+1 with data F0/20, `alu_add` alone at k+2, `rsp_valid` at k+3 with `rsp_data`=0x10, `rsp_ov`=1, `rsp_err`=0.
- Compare: op 7, a=b=0x5A → `alu_cmp` pulses one cycle; response `rsp_eq`=1, `rsp_data`=0x00. Repeat with b=0x5B → `rsp_eq`=0.
- Illegal op 12 → `rsp_valid` at k+1, `rsp_err`=1, `rsp_data`=0, no write enable or strobe ever high.
- Halt blocking with `HLT_BLOCK`=1:
  - op 8 → `rsp_hlt`=1 at k+2.
  - Then op 0 → `rsp_err`=1.
  - Then op 9 → `alu_flag_res` pulses and `rsp_hlt`=0.
  - Then op 4, a=0xCC, b=0xAA → `rsp_data`=0x88.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → all `rsp_*` stable, `req_ready`=0. Release → IDLE next cycle, `req_ready`=1.
- Reset during EXEC of sub (a=0x03, b=0x05) → next cycle all strobes 0 and `rsp_valid`=0; the following request executes normally with correct latency.
